// File: rtl/btobcd_pkg.sv
// rtl/btobcd_pkg.sv - shared types and helpers for the sequential binary-to-BCD converter
//
// Purpose : FSM state encoding and the minimum-digit helper used by the
//           elaboration-time width check in btobcd_seq.
// Contents: state_t    - IDLE / SHIFT / DONE
//           bcd_digits - smallest DIGITS with 10^DIGITS >= 2^width

package btobcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ceil(width * log10(2)). 10^d == 2^w never holds for w >= 1, so this
  // equals floor(width * log10(2)) + 1. A 9-digit fixed-point log10(2)
  // keeps the result exact far beyond any practical width.
  function automatic int bcd_digits(input int width);
    longint w;
    longint scaled;
    w      = longint'(width);
    scaled = (w * 64'sd301029995) / 64'sd1000000000;
    return int'(scaled) + 1;
  endfunction

endpackage

// File: rtl/btobcd_seq_if.sv
// rtl/btobcd_seq_if.sv - handshake bundle between a binary producer, the converter and a BCD consumer
//
// Purpose : groups the input and output valid/ready channels plus the busy flag.
// Signals : in_valid/in_ready/b      - binary input channel
//           out_valid/out_ready/bcd  - packed BCD result channel (digit 0 in bcd[3:0])
//           busy                     - conversion in progress
// Modports: master - the side that supplies b and consumes bcd
//           slave  - the converter

interface btobcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);

  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    b;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;

  modport master (
    output in_valid, b, out_ready,
    input  in_ready, out_valid, bcd, busy
  );

  modport slave (
    input  in_valid, b, out_ready,
    output in_ready, out_valid, bcd, busy
  );

endinterface

// File: rtl/btobcd_seq_digit_adj.sv
// rtl/btobcd_seq_digit_adj.sv - one BCD digit "if >= 5 add 3" correction cell
//
// Purpose : pre-shift correction for the double-dabble step. Inputs are
//           always 0..9, so the result (at most 12) never leaves the nibble.
// Ports   : din  - current digit value
//           dout - corrected digit value

module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/btobcd_seq.sv
// rtl/btobcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter with valid/ready handshakes
//
// Purpose : converts a BIN_W-bit unsigned value to DIGITS packed BCD digits,
//           one double-dabble step per clock.
// Ports   : clk - clock, rising edge
//           rst - synchronous active-high reset
//           bus - btobcd_seq_if slave: in_valid/in_ready/b input channel,
//                 out_valid/out_ready/bcd result channel, busy flag

module btobcd_seq
  import btobcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  btobcd_seq_if.slave  bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int SR_W  = ACC_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 1) begin : g_bad_width
    $error("btobcd_seq: BIN_W must be at least 1");
  end
  if (DIGITS < bcd_digits(BIN_W)) begin : g_bad_digits
    $error("btobcd_seq: DIGITS too small for BIN_W");
  end

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [SR_W-1:0]    sr;        // {accumulator, binary remainder}
  logic [ACC_W-1:0]   acc_adj;
  logic [SR_W-1:0]    pre;
  logic [SR_W-1:0]    shifted;
  logic [ACC_W-1:0]   bcd_q;
  logic               accept;
  logic               last_step;
  logic               in_ready_c;
  logic               out_valid_c;
  logic               busy_c;

  // Every accumulator digit is corrected in parallel before the shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sr[BIN_W + 4*i +: 4]),
      .dout (acc_adj[4*i +: 4])
    );
  end

  // The binary MSB moves into bit 0 of digit 0.
  assign pre       = {acc_adj, sr[BIN_W-1:0]};
  assign shifted   = pre << 1;
  assign last_step = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so a reset cycle never looks ready or accepts.
        in_ready_c = !rst;
        if (bus.in_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      cnt   <= '0;
      bcd_q <= '0;
    end else if (accept) begin
      sr  <= {{ACC_W{1'b0}}, bus.b};
      cnt <= CNT_W'(BIN_W);
    end else if (state == SHIFT) begin
      sr  <= shifted;
      cnt <= cnt - CNT_W'(1);
      // Result register is loaded on the final step only, so it is
      // untouched while a later conversion is running.
      if (last_step) bcd_q <= shifted[SR_W-1:BIN_W];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.bcd       = bcd_q;

endmodule

// File: doc/btobcd_seq.md
# btobcd_seq

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It supersedes the fixed 4-bit combinational converter: any binary width, a configurable digit count, one algorithm step per clock, and valid/ready handshakes on both input and output. It sits between binary datapath results and BCD display/decoder logic.

## Interface
Parameters:
- `BIN_W`, default 8: binary input width; legal range ≥ 1.
- `DIGITS`, default 3: number of BCD output digits. Must satisfy 10^DIGITS ≥ 2^BIN_W; elaboration fails otherwise.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `b` holds a value to convert.
- `in_ready`, output, 1: converter can accept an input.
- `b`, input, BIN_W: unsigned binary value.
- `out_valid`, output, 1: `bcd` holds a completed result.
- `out_ready`, input, 1: consumer accepts the result.
- `bcd`, output, 4*DIGITS: packed BCD result; digit 0 (ones) is in bits [3:0].
- `busy`, output, 1: conversion in progress (state SHIFT).

## Operation
- The FSM has three states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `b` into the binary shift register, clear the BCD accumulator, set `cnt`=BIN_W, then go to SHIFT.
  - SHIFT: once per cycle, every digit of the accumulator that is ≥ 5 gets +3 (all digits in parallel). Then shift {accumulator, binary} left by 1, so the binary MSB enters digit 0 bit 0. Decrement `cnt`. When `cnt` reaches 1 before the step, go to DONE.
  - DONE: `out_valid`=1 and `bcd` = accumulator. On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` in SHIFT or DONE is ignored; the input is not consumed.
- `b` is sampled only on the accept edge. Later changes to `b` have no effect.
- `bcd` is registered. It stays stable, and only changes, while `out_valid`=1 and is not yet accepted.
- Every output digit is in the range 0–9. Unused high digits read 0.
- Arithmetic:
  - Shift-register width is 4*DIGITS+BIN_W.
  - The add-3 carry stays within the digit: the maximum pre-adjust value is 9, which becomes 12 after adjust.
  - `cnt` width is $clog2(BIN_W+1).

## Timing
- Reset values: `in_ready`=0 during the reset cycle, then 1 in IDLE from the first cycle after reset. `out_valid`=0, `busy`=0, `bcd`=0. Accumulator, shift register and `cnt` are cleared; state is IDLE.
- Latency: call the accept edge E0. `busy` is high after E0. Shift steps occur on edges E1..E_BIN_W. `out_valid` is high after E_BIN_W, which is BIN_W cycles after acceptance.
- Throughput: one conversion per BIN_W+2 cycles when `out_ready`=1 is held. This covers BIN_W SHIFT cycles, 1 DONE cycle and 1 IDLE cycle.
- Output stall: `out_ready`=0 holds DONE and `bcd` indefinitely, and no new input is accepted.
- Reset mid-conversion, in SHIFT or DONE: the next edge returns to IDLE with every output at its reset value. The partial result is discarded and never presented.
- `rst` and `in_valid` asserted in the same cycle: reset wins and nothing is accepted.
- BIN_W=1: a single SHIFT cycle, so `out_valid` appears 1 cycle after accept.

## Structure
- Package `btobcd_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the function `bcd_digits(width)`, returning the minimum legal DIGITS, used by the elaboration check.
- Sub-module `bcd_digit_adj`: a combinational 4-bit "if ≥5 add 3" cell. It is instantiated DIGITS times with a generate loop inside `btobcd_seq`.
- The top level holds the FSM, `cnt`, the shift register and the output register.

## Test plan
- Reset: assert `rst` for 2 cycles mid-idle. Required: `out_valid`=0, `busy`=0, `bcd`=0, and `in_ready`=1 in the first cycle after `rst` drops.
- Default params, `b`=8'd255 with `out_ready`=1. Required: `busy` for 8 cycles, then `out_valid`=1 with `bcd`=12'h255. Also convert 0, which must give 12'h000, and 8'd100, which must give 12'h100.
- Exhaustive sweep 0–255 through back-to-back handshakes, checked against a golden decimal model. Required: every result matches, and the accept-to-accept spacing is exactly 10 cycles.
- Stall: hold `out_ready`=0 for 20 cycles after conversion of 8'd73. Required: `bcd`=12'h073 stays stable, `in_ready`=0, and an `in_valid` pulse with `b`=8'd5 is not accepted. After release, that pending value is accepted and gives 12'h005.
- Abort: assert `rst` on the 4th SHIFT cycle of 8'd200. Required: no `out_valid` appears, and the next conversion of 8'd42 gives 12'h042.
- Parameter variants:
  - BIN_W=4, DIGITS=2: sweep 0–15, for example 13 → 8'h13.
  - BIN_W=16, DIGITS=5: 65535 → 20'h65535, with latency 16.
